pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hold PC and suppress fetch this cycle.
REQ-005 branch_taken  input  1  conditional branch resolved taken.
REQ-006 branch_base  input  32  PC+4 of the branch instruction.
REQ-007 branch_offset  input  32  sign-extended immediate already shifted left by 2.
REQ-008 jump  input  1  J/JAL redirect request.
REQ-009 jump_index  input  26  instr_index field of J/JAL.
REQ-010 jr  input  1  JR/JALR redirect request.
REQ-011 jr_target  input  32  register-sourced target.
REQ-012 imem_ack  input  1  instruction memory accepted current pc.
REQ-013 pc  output  32  current fetch address (registered).
REQ-014 pc_plus4  output  32  pc + 4, combinational from pc.
REQ-015 imem_req  output  1  fetch request for pc.
REQ-016 fetch_valid  output  1  instruction at pc delivered this cycle.
REQ-017 flush  output  1  squash younger in-flight instruction (registered).
REQ-018 misaligned  output  1  sticky: a redirect target had nonzero bits [1:0].

Function
REQ-019 States: BOOT, FETCH, REDIRECT; BOOT entered on reset, BOOT -> FETCH unconditionally after one cycle.
REQ-020 imem_req = 1 only in FETCH with stall = 0.
REQ-021 fetch_valid = imem_ack AND state FETCH AND stall = 0; ack in BOOT or REDIRECT ignored.
REQ-022 Sequential advance: in FETCH, fetch_valid = 1 and no redirect -> pc <= pc + 4 next edge.
REQ-023 Redirect priority: jr > jump > branch_taken; lower-priority requests in the same cycle discarded.
REQ-024 Branch target = branch_base + branch_offset, modulo 2^32 (wrap, no overflow flag).
REQ-025 Jump target = {pc_plus4[31:28], jump_index, 2'b00}.
REQ-026 JR target = {jr_target[31:2], 2'b00}; if jr_target[1:0] != 0, misaligned set to 1 and held until reset.
REQ-027 Any redirect, in any state except BOOT, overrides stall: pc <= target next edge, state -> REDIRECT, flush = 1 for exactly that REDIRECT cycle.
REQ-028 REDIRECT -> FETCH after one cycle; a new redirect arriving in REDIRECT is accepted (pc reloaded, stays REDIRECT one more cycle, flush stays 1).
REQ-029 Redirects during BOOT ignored.
REQ-030 stall = 1 with no redirect: pc, state unchanged; no fetch_valid.
REQ-031 pc wrap: pc = 32'hFFFF_FFFC sequential advance -> 32'h0000_0000.
REQ-032 Redirect and imem_ack in same FETCH cycle: fetch_valid = 1 for current pc, pc <= target (not pc+4).

Reset
REQ-033 On rst assertion, asynchronously: pc = RESET_PC, state = BOOT, flush = 0, misaligned = 0.
REQ-034 During BOOT: imem_req = 0, fetch_valid = 0.
REQ-035 Reset mid-REDIRECT or mid-stall discards all pending redirect state.

Structure
REQ-036 Shared package holds state encoding (BOOT=2'd0, FETCH=2'd1, REDIRECT=2'd2) and PC_INCR = 4.
REQ-037 One sub-module: pc_target_mux (combinational priority select of branch/jump/jr target and misalignment detect); sequential logic stays in pc_fetch_unit.

Verification
REQ-038 Reset release, imem_ack = 1 constant -> BOOT 1 cycle, then pc 0x0, 0x4, 0x8 with fetch_valid = 1 each cycle.
REQ-039 pc = 0x100, branch_base = 0x104, branch_offset = 0xFFFF_FFF0, branch_taken -> next pc = 0xF4, flush = 1 one cycle, then fetch resumes at 0xF4.
REQ-040 pc_plus4 = 0x4000_0010, jump_index = 0x0000040, jump and branch_taken together -> pc = 0x4000_0100, branch ignored.
REQ-041 stall = 1 three cycles at pc = 0x20 -> pc holds 0x20, imem_req = 0; jr_target = 0x203 during stall -> pc = 0x200, misaligned = 1 sticky until rst.
REQ-042 pc = 0xFFFF_FFFC, ack -> pc = 0x0; rst pulsed mid-REDIRECT -> pc = RESET_PC, flush = 0 immediately.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: FSM state encoding, PC increment
// and the J/JAL target formation helper.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INCR = 32'd4;

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between the PC fetch unit (master) and the
// instruction memory (slave).
interface pc_fetch_unit_if;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        imem_ack;
  logic        fetch_valid;

  modport master (output pc, pc_plus4, imem_req, fetch_valid, input imem_ack);
  modport slave  (input pc, pc_plus4, imem_req, fetch_valid, output imem_ack);
endinterface

// File: rtl/pc_target_mux.sv
// Priority select of the redirect target (jr > jump > branch) and detection of
// a target whose low two address bits are nonzero.
module pc_target_mux
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_base_i,
  input  logic [31:0] branch_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  logic [31:0] branch_sum;

  // Wraps modulo 2^32; overflow is deliberately not reported.
  assign branch_sum = branch_base_i + branch_offset_i;

  always_comb begin
    redirect_o   = 1'b0;
    target_o     = '0;
    misaligned_o = 1'b0;
    if (jr_i) begin
      redirect_o   = 1'b1;
      target_o     = {jr_target_i[31:2], 2'b00};
      misaligned_o = (jr_target_i[1:0] != 2'b00);
    end else if (jump_i) begin
      redirect_o   = 1'b1;
      target_o     = jump_target(pc_plus4_i, jump_index_i);
    end else if (branch_taken_i) begin
      redirect_o   = 1'b1;
      target_o     = branch_sum;
      misaligned_o = (branch_sum[1:0] != 2'b00);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: BOOT/FETCH/REDIRECT control, sequential PC
// advance, redirect handling with one-cycle flush, and sticky misalignment.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic [31:0]           branch_base_i,
  input  logic [31:0]           branch_offset_i,
  input  logic                  jump_i,
  input  logic [25:0]           jump_index_i,
  input  logic                  jr_i,
  input  logic [31:0]           jr_target_i,
  pc_fetch_unit_if.master       imem,
  output logic                  flush_o,
  output logic                  misaligned_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         flush_q, flush_d;
  logic         misaligned_q, misaligned_d;

  logic [31:0]  pc_plus4;
  logic         req;
  logic         fetch_valid;
  logic         redirect;
  logic [31:0]  target;
  logic         target_misaligned;

  assign pc_plus4    = pc_q + PC_INCR;
  assign req         = (state_q == ST_FETCH) && !stall_i;
  assign fetch_valid = req && imem.imem_ack;

  pc_target_mux u_target_mux (
    .pc_plus4_i      (pc_plus4),
    .branch_taken_i  (branch_taken_i),
    .branch_base_i   (branch_base_i),
    .branch_offset_i (branch_offset_i),
    .jump_i          (jump_i),
    .jump_index_i    (jump_index_i),
    .jr_i            (jr_i),
    .jr_target_i     (jr_target_i),
    .redirect_o      (redirect),
    .target_o        (target),
    .misaligned_o    (target_misaligned)
  );

  // A redirect wins over stall and over the sequential advance; the fetch
  // completing in the same cycle is still reported for the old pc.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_d      = 1'b0;
    misaligned_d = misaligned_q;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH, ST_REDIRECT: begin
        if (redirect) begin
          state_d      = ST_REDIRECT;
          pc_d         = target;
          flush_d      = 1'b1;
          misaligned_d = misaligned_q | target_misaligned;
        end else begin
          state_d = ST_FETCH;
          if (fetch_valid) pc_d = pc_plus4;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      flush_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_q      <= flush_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem.pc          = pc_q;
  assign imem.pc_plus4    = pc_plus4;
  assign imem.imem_req    = req;
  assign imem.fetch_valid = fetch_valid;
  assign flush_o          = flush_q;
  assign misaligned_o     = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized bench for pc_fetch_unit against a cycle-level
// behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br, jmp, jr;
  logic [31:0] bbase, boff, jrt;
  logic [25:0] jidx;
  logic        flush, mis;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: first cycle after reset, redirect cycle pending, pc, sticky flag
  bit          m_boot;
  bit          m_redir;
  logic [31:0] m_pc;
  bit          m_mis;

  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .branch_taken_i  (br),
    .branch_base_i   (bbase),
    .branch_offset_i (boff),
    .jump_i          (jmp),
    .jump_index_i    (jidx),
    .jr_i            (jr),
    .jr_target_i     (jrt),
    .imem            (bus.master),
    .flush_o         (flush),
    .misaligned_o    (mis)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_redir = 1'b0;
    m_pc    = RST_PC;
    m_mis   = 1'b0;
  endtask

  task automatic idle();
    stall = 1'b0; br = 1'b0; jmp = 1'b0; jr = 1'b0;
    bbase = '0; boff = '0; jrt = '0; jidx = '0;
    bus.imem_ack = 1'b1;
  endtask

  // Called just after a rising edge with inputs already applied: checks the
  // current outputs, advances the model, and waits for the next edge.
  task automatic cycle();
    bit          exp_req, exp_fv, redir, tmis;
    logic [31:0] tgt;
    #1;
    exp_req = !m_boot && !m_redir && !stall;
    exp_fv  = exp_req && bus.imem_ack;
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
    chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, exp_fv});
    chk("flush", {31'd0, flush}, {31'd0, m_redir});
    chk("misaligned", {31'd0, mis}, {31'd0, m_mis});
    if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      redir = 1'b1;
      tmis  = 1'b0;
      tgt   = '0;
      if (jr) begin
        tgt  = jrt & ~32'd3;
        tmis = (jrt % 4) != 0;
      end else if (jmp) begin
        tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, jidx} << 2);
      end else if (br) begin
        tgt  = bbase + boff;
        tmis = (tgt % 4) != 0;
      end else begin
        redir = 1'b0;
      end
      if (redir) begin
        m_pc    = tgt;
        m_redir = 1'b1;
        m_mis   = m_mis | tmis;
      end else begin
        m_redir = 1'b0;
        if (exp_fv) m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_jr(input logic [31:0] t);
    jr = 1'b1; jrt = t;
    cycle();
    idle();
    cycle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, RST_PC);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_mis", {31'd0, mis}, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    rst = 1'b0;

    // Boot then sequential fetch with ack held high
    cycle();
    chk("seq0", bus.pc, 32'h0);
    cycle();
    chk("seq4", bus.pc, 32'h4);
    cycle();
    chk("seq8", bus.pc, 32'h8);
    cycle();

    // Backward branch from 0x100, taken in the same cycle as an ack
    go_jr(32'h100);
    chk("at_100", bus.pc, 32'h100);
    br = 1'b1; bbase = 32'h104; boff = 32'hFFFF_FFF0;
    cycle();
    chk("br_pc", bus.pc, 32'hF4);
    chk("br_flush", {31'd0, flush}, 32'd1);
    idle();
    cycle();
    chk("br_pc_hold", bus.pc, 32'hF4);
    chk("br_flush_end", {31'd0, flush}, 32'd0);
    cycle();
    chk("br_resume", bus.pc, 32'hF8);

    // Jump beats a simultaneous branch
    go_jr(32'h4000_000C);
    jmp = 1'b1; jidx = 26'h40; br = 1'b1; bbase = 32'h10; boff = 32'h10;
    cycle();
    chk("jmp_pc", bus.pc, 32'h4000_0100);
    idle();
    cycle();

    // Stall hold, then misaligned jr under stall, then back-to-back redirect
    go_jr(32'h20);
    stall = 1'b1;
    repeat (3) cycle();
    chk("stall_pc", bus.pc, 32'h20);
    jr = 1'b1; jrt = 32'h203;
    cycle();
    chk("jr_pc", bus.pc, 32'h200);
    chk("jr_mis", {31'd0, mis}, 32'd1);
    jrt = 32'h300;
    cycle();
    chk("rr_pc", bus.pc, 32'h300);
    chk("rr_flush", {31'd0, flush}, 32'd1);
    idle();
    repeat (4) cycle();
    chk("mis_sticky", {31'd0, mis}, 32'd1);

    // Wrap at the top of the address space
    go_jr(32'hFFFF_FFFC);
    cycle();
    chk("wrap", bus.pc, 32'h0);

    // Asynchronous reset in the middle of a redirect cycle
    jr = 1'b1; jrt = 32'h40;
    cycle();
    idle();
    rst = 1'b1;
    #1;
    chk("arst_pc", bus.pc, RST_PC);
    chk("arst_flush", {31'd0, flush}, 32'd0);
    chk("arst_mis", {31'd0, mis}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Redirect presented during BOOT is ignored, including its misalignment
    jr = 1'b1; jrt = 32'h501;
    cycle();
    idle();
    chk("boot_ignore_pc", bus.pc, RST_PC);
    chk("boot_ignore_mis", {31'd0, mis}, 32'd0);
    cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      stall        = ($urandom % 4) == 0;
      bus.imem_ack = ($urandom % 4) != 0;
      jr           = ($urandom % 12) == 0;
      jmp          = ($urandom % 10) == 0;
      br           = ($urandom % 8) == 0;
      jrt          = $urandom;
      if (($urandom % 4) != 0) jrt[1:0] = 2'b00;
      jidx         = 26'($urandom);
      bbase        = $urandom & ~32'd3;
      boff         = $urandom & ~32'd3;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
